// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared constants, opcodes and fetch state encoding for the RV32I front end
package rv32i_pkg;
  localparam logic [31:0] NOP_IW = 32'h0000_0013;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  typedef enum logic [1:0] {ST_FILL, ST_RUN, ST_FLUSH, ST_HALT} fetch_state_e;
  function automatic logic is_ebreak(input logic [31:0] iw);
    return iw[6:0] == OP_SYSTEM && iw[31:20] == 12'h001;
  endfunction
endpackage

// File: rtl/rv32i_pc_next.sv
// rv32i_pc_next: next fetch PC select between redirect target, sequential advance and hold
module rv32i_pc_next (
  input  logic [31:0] pc_i,
  input  logic        adv_i,
  input  logic        jump_i,
  input  logic [31:0] jump_addr_i,
  output logic [31:0] pc_d_o
);
  // redirect wins, targets are forced word aligned; the +4 wraps naturally at 2^32
  always_comb pc_d_o = jump_i ? (jump_addr_i & ~32'h3) : adv_i ? pc_i + 32'd4 : pc_i;
endmodule

// File: rtl/rv32i_fetch.sv
// rv32i_fetch: instruction fetch stage with fill, redirect flush, stall hold and EBREAK halt
module rv32i_fetch #(
  parameter logic [31:0] RESET_VECTOR = rv32i_pkg::RESET_VECTOR_DEFAULT,
  parameter logic [31:0] NOP_IW = rv32i_pkg::NOP_IW
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  output logic        imem_rd_en,
  input  logic [31:0] imem_data,
  input  logic        stall_in,
  input  logic        jump_en_in,
  input  logic [31:0] jump_addr_in,
  output logic [31:0] pc_out,
  output logic [31:0] iw_out,
  output logic        jump_en_out,
  output logic        halted_out
);
  import rv32i_pkg::*;
  fetch_state_e state_q, state_d;
  logic [31:0] pc_q, pc_d, pc_out_q, pc_out_d, hold_q, hold_d;
  logic hold_v_q, hold_v_d, active, run, jmp;
  rv32i_pc_next u_pc_next (
    .pc_i(pc_q),
    .adv_i(imem_rd_en),
    .jump_i(jmp),
    .jump_addr_i(jump_addr_in),
    .pc_d_o(pc_d)
  );
  // outputs and next state; a stalled RUN word is parked in hold_q until the cycle after release
  always_comb begin
    active = state_q != ST_HALT;
    run = state_q == ST_RUN;
    jmp = active & jump_en_in;
    imem_addr = pc_q;
    imem_rd_en = active & ~stall_in;
    iw_out = run ? (hold_v_q ? hold_q : imem_data) : NOP_IW;
    jump_en_out = state_q == ST_FLUSH;
    halted_out = state_q == ST_HALT;
    pc_out = pc_out_q;
    hold_v_d = run & stall_in & ~jmp;
    hold_d = hold_v_d ? iw_out : hold_q;
    pc_out_d = (imem_rd_en | jmp) ? pc_q : pc_out_q;
    state_d = !active ? ST_HALT :
              jmp ? ST_FLUSH :
              stall_in ? state_q :
              (run && is_ebreak(iw_out)) ? ST_HALT : ST_RUN;
  end
  // state, PC and hold registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FILL;
      pc_q <= RESET_VECTOR;
      pc_out_q <= 32'd0;
      hold_q <= NOP_IW;
      hold_v_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      pc_out_q <= pc_out_d;
      hold_q <= hold_d;
      hold_v_q <= hold_v_d;
    end
  end
endmodule

// File: doc/rv32i_fetch.md
RV32I_FETCH -- requirements
Module: rv32i_fetch

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, the PC loaded on reset.
REQ-002 SHALL have parameter NOP_IW, default 32'h0000_0013, the bubble instruction (ADDI x0,x0,0).
REQ-003 clk  input  1  system clock; reset reset, synchronous, active-high; clock clk.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 imem_addr  output  32  instruction memory word address (byte address, bits[1:0]=0).
REQ-006 imem_rd_en  output  1  read strobe to instruction memory.
REQ-007 imem_data  input  32  read data, valid exactly one cycle after imem_addr/imem_rd_en.
REQ-008 stall_in  input  1  downstream hold request; freeze PC and outputs.
REQ-009 jump_en_in  input  1  redirect request from decode stage.
REQ-010 jump_addr_in  input  32  redirect target from decode stage.
REQ-011 pc_out  output  32  PC of iw_out, to decode stage.
REQ-012 iw_out  output  32  instruction word, to decode stage.
REQ-013 jump_en_out  output  1  high in the cycle iw_out is the squashed wrong-path slot after a redirect.
REQ-014 halted_out  output  1  high while in HALT.

Function
REQ-015 SHALL implement states FILL, RUN, FLUSH, HALT; FILL entered on reset.
REQ-016 imem_addr SHALL equal pc_q combinationally; imem_rd_en SHALL be 1 in FILL/RUN/FLUSH when stall_in=0, else 0.
REQ-017 FILL: iw_out=NOP_IW; next state RUN unless stall_in.
REQ-018 RUN, no stall, no jump: pc_q <= pc_q+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0); pc_out <= pc_q; iw_out = imem_data.
REQ-019 jump_en_in=1 in FILL/RUN/FLUSH: pc_q <= {jump_addr_in[31:2],2'b00}; next state FLUSH; jump has priority over stall_in.
REQ-020 FLUSH: iw_out=NOP_IW, jump_en_out=1 for exactly one cycle; next state RUN (or FLUSH on a further jump).
REQ-021 stall_in=1 in RUN with no jump: pc_q, pc_out, state held; iw_out held via hold register captured on stall entry; iw_out after stall release equals the held word, no instruction lost or duplicated.
REQ-022 iw_out from RUN with opcode 7'b1110011 and iw[31:20]=12'h001 (EBREAK): EBREAK SHALL be presented once, then state HALT next cycle.
REQ-023 HALT: pc_q frozen, iw_out=NOP_IW, imem_rd_en=0, halted_out=1; jump_en_in and stall_in ignored; exit only by reset.
REQ-024 Redirect in the same cycle as EBREAK on iw_out: jump wins, EBREAK squashed, no HALT.
REQ-025 Pipeline latency: address issue to iw_out = 1 cycle; jump_en_in to first target word on iw_out = 2 cycles.
REQ-026 jump_en_out SHALL be 0 in all states except FLUSH.

Reset
REQ-027 On reset: pc_q=RESET_VECTOR, pc_out=0, iw_out=NOP_IW, jump_en_out=0, halted_out=0, hold register=NOP_IW, state=FILL.
REQ-028 Reset SHALL override all other inputs in any state, including mid-stall, mid-FLUSH and HALT.

Structure
REQ-029 Shared package rv32i_pkg SHALL hold NOP_IW, opcode constants (OP_SYSTEM=7'b1110011, OP_JAL, OP_JALR, OP_BRANCH), the fetch state enum and RESET_VECTOR default.
REQ-030 PC next-value selection SHALL be a sub-module rv32i_pc_next (combinational: pc+4 / jump target / hold); the FSM and output registers stay in rv32i_fetch.

Verification
REQ-031 Reset release, memory returns word=addr -> pc_out 0,4,8,12 on consecutive cycles, first iw_out NOP_IW.
REQ-032 jump_en_in=1, jump_addr_in=32'h0000_0103 at pc_q=8 -> imem_addr 32'h100 next cycle, iw_out NOP_IW with jump_en_out=1 one cycle, then pc_out=32'h100.
REQ-033 stall_in high 3 cycles at pc_out=12 -> pc_out, iw_out constant 3 cycles, then 16 follows with no duplicate.
REQ-034 EBREAK (32'h0010_0073) at address 20 -> iw_out shows it once, halted_out=1 next cycle, imem_rd_en=0, later jump ignored.
REQ-035 RESET_VECTOR=32'hFFFF_FFF8 -> pc_out sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-036 reset asserted during FLUSH and during HALT -> all outputs equal REQ-027 values next cycle.
